// File: rtl/cfu_requant_pipe.sv
// Requantization back end for the CFU matrix engine: four int32 lanes per beat are
// biased, scaled (gemmlowp SRDHM), rounding-shifted, offset and clamped to packed int8.
module cfu_requant_pipe #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_acc,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [31:0]      cfg_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             idle,
  output logic             cfg_err,
  output logic [CNT_W-1:0] out_count
);

  // Saturating rounding doubling high multiply; division by 2^31 truncates toward zero.
  function automatic logic [31:0] srdhm(input logic [63:0] p, input logic sat);
    logic [63:0] sum_v;
    logic [63:0] adj_v;
    sum_v = p + (p[63] ? 64'hFFFF_FFFF_C000_0001 : 64'h0000_0000_4000_0000);
    adj_v = sum_v[63] ? (sum_v + 64'h0000_0000_7FFF_FFFF) : sum_v;
    return sat ? 32'h7FFF_FFFF : adj_v[62:31];
  endfunction

  // Rounding divide by power of two (ties away from zero), then offset and int8 clamp.
  function automatic logic [7:0] rdbp_clamp(input logic [31:0] y, input logic [4:0] e,
                                            input logic [31:0] offset,
                                            input logic [7:0] amin, input logic [7:0] amax);
    logic [31:0] mask_v, rem_v, thr_v, z_v, w_v, lo_v, hi_v;
    logic [7:0]  q_v;
    mask_v = (32'd1 << e) - 32'd1;
    rem_v  = y & mask_v;
    thr_v  = (mask_v >> 1) + {31'd0, y[31]};
    z_v    = $signed(y) >>> e;
    z_v    = z_v + {31'd0, (rem_v > thr_v)};
    w_v    = z_v + offset;
    lo_v   = {{24{amin[7]}}, amin};
    hi_v   = {{24{amax[7]}}, amax};
    if ($signed(w_v) > $signed(hi_v)) begin
      q_v = amax;
    end else if ($signed(w_v) < $signed(lo_v)) begin
      q_v = amin;
    end else begin
      q_v = w_v[7:0];
    end
    return q_v;
  endfunction

  logic [31:0]      bias_r [LANES];
  logic [31:0]      mult_r;
  logic [5:0]       shift_r;
  logic [31:0]      offset_r;
  logic [7:0]       act_min_r;
  logic [7:0]       act_max_r;

  logic             v1_r, v2_r, v3_r, v4_r;
  logic [127:0]     acc_r;
  logic [31:0]      x_s [LANES];
  logic [31:0]      x_r [LANES];
  logic [63:0]      p_s [LANES];
  logic [63:0]      p_r [LANES];
  logic [LANES-1:0] sat_s;
  logic [LANES-1:0] sat_r;
  logic [31:0]      y_s [LANES];
  logic [31:0]      y_r [LANES];
  logic [31:0]      pack_s;
  logic [5:0]       shift_neg_s;
  logic [4:0]       rshift_s;
  logic             en_s;

  assign en_s     = !(out_valid && !out_ready);
  assign in_ready = en_s;
  assign idle     = !(v1_r | v2_r | v3_r | v4_r);

  // Right-shift amount for negative shift settings, limited to 31.
  always_comb begin
    shift_neg_s = 6'd0 - shift_r;
    if (!shift_r[5]) begin
      rshift_s = 5'd0;
    end else if (shift_neg_s[5]) begin
      rshift_s = 5'd31;
    end else begin
      rshift_s = shift_neg_s[4:0];
    end
  end

  // Per-lane datapath for S1 (bias, left shift), S2 (multiply), S3 (SRDHM), S4 (pack).
  always_comb begin
    logic [31:0] sum_v;
    pack_s = 32'd0;
    sat_s  = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_v = acc_r[127-32*l -: 32] + bias_r[l];
      if (!shift_r[5] && (shift_r != 6'd0)) begin
        x_s[l] = sum_v << shift_r[4:0];
      end else begin
        x_s[l] = sum_v;
      end
      p_s[l]   = {{32{x_r[l][31]}}, x_r[l]} * {{32{mult_r[31]}}, mult_r};
      sat_s[l] = (x_r[l] == 32'h8000_0000) && (mult_r == 32'h8000_0000);
      y_s[l]   = srdhm(p_r[l], sat_r[l]);
      pack_s[31-8*l -: 8] = rdbp_clamp(y_r[l], rshift_s, offset_r, act_min_r, act_max_r);
    end
  end

  // Configuration registers; writes land only while the pipeline is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < LANES; l++) bias_r[l] <= 32'd0;
      mult_r    <= 32'h4000_0000;
      shift_r   <= 6'd0;
      offset_r  <= 32'd0;
      act_min_r <= 8'h80;
      act_max_r <= 8'h7F;
      cfg_err   <= 1'b0;
    end else begin
      if (cfg_we && idle) begin
        case (cfg_addr)
          3'd0, 3'd1, 3'd2, 3'd3: bias_r[cfg_addr[1:0]] <= cfg_data;
          3'd4:    mult_r   <= cfg_data;
          3'd5:    shift_r  <= cfg_data[5:0];
          3'd6:    offset_r <= cfg_data;
          3'd7: begin
            act_max_r <= cfg_data[15:8];
            act_min_r <= cfg_data[7:0];
          end
          default: ;
        endcase
      end
      if (cfg_we && !idle) cfg_err <= 1'b1;
    end
  end

  // Pipeline registers; a single enable advances or freezes every stage together.
  always_ff @(posedge clk) begin
    if (reset) begin
      {v1_r, v2_r, v3_r, v4_r} <= 4'd0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_count <= '0;
      acc_r     <= 128'd0;
      sat_r     <= '0;
      for (int l = 0; l < LANES; l++) begin
        x_r[l] <= 32'd0;
        p_r[l] <= 64'd0;
        y_r[l] <= 32'd0;
      end
    end else begin
      if (out_valid && out_ready) out_count <= out_count + {{(CNT_W-1){1'b0}}, 1'b1};
      if (en_s) begin
        v1_r      <= in_valid;
        v2_r      <= v1_r;
        v3_r      <= v2_r;
        v4_r      <= v3_r;
        out_valid <= v4_r;
        acc_r     <= in_acc;
        sat_r     <= sat_s;
        x_r       <= x_s;
        p_r       <= p_s;
        y_r       <= y_s;
        if (v4_r) out_data <= pack_s;
      end
    end
  end

endmodule

// File: tb/tb_cfu_requant_pipe.sv
// Scoreboard bench for cfu_requant_pipe: directed beats push expected words,
// an independent monitor pops and compares on each output handshake.
module tb_cfu_requant_pipe;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_acc = 128'd0;
  logic         cfg_we = 1'b0;
  logic [2:0]   cfg_addr = 3'd0;
  logic [31:0]  cfg_data = 32'd0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic         idle;
  logic         cfg_err;
  logic [15:0]  out_count;

  typedef struct {
    logic [31:0] data;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_m;
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;

  cfu_requant_pipe #(.LANES(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .idle(idle), .cfg_err(cfg_err),
    .out_count(out_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] pk(input int a, input int b, input int c, input int d);
    return {a, b, c, d};
  endfunction

  // Monitor: compare each word as it is about to be consumed.
  always @(negedge clk) begin
    #2;
    if (!reset && out_valid) begin
      if (!out_ready) begin
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end else if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_out: got %h, expected no output", out_data);
      end else begin
        e_m = exp_q.pop_front();
        check("out_data", out_data, e_m.data);
        if (e_m.lat) check("latency", 32'(cyc - e_m.acc_cyc), 32'd5);
      end
    end
  end

  task automatic send(input logic [127:0] acc, input logic [31:0] exp, input bit lat);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_acc   = acc;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout: got in_ready=0, expected 1");
    end else begin
      exp_q.push_back('{data: exp, acc_cyc: cyc, lat: lat});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic cfg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    #3;
    if (exp_q.size() != 0 || out_valid) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    check("rst_out_count", {16'd0, out_count}, 32'd0);

    // Default config
    send(pk(100, -100, 0, 1000), 32'h32CE007F, 1'b1);
    drain();
    check("count_after_one", {16'd0, out_count}, 32'd1);

    // Rounding right shift, ties away from zero
    cfg(3'd5, 32'h0000_003F);
    cfg(3'd4, 32'h7FFF_FFFF);
    send(pk(3, -3, 5, -5), 32'h02FE03FD, 1'b0);
    drain();

    // SRDHM saturation corner
    cfg(3'd5, 32'd0);
    cfg(3'd4, 32'h8000_0000);
    send(pk(32'h8000_0000, 1, 0, -1), 32'h7FFF0001, 1'b0);
    drain();

    // Output offset with clamping at both ends
    cfg(3'd4, 32'h4000_0000);
    cfg(3'd6, 32'hFFFF_FF80);
    send(pk(1000, 0, 256, -2), 32'h7F800080, 1'b0);
    drain();

    // Per-lane bias and positive (left) shift
    do_reset();
    cfg(3'd1, 32'd10);
    cfg(3'd5, 32'd2);
    send(pk(3, 5, -7, 0), 32'h061EF200, 1'b0);
    drain();

    // Inverted clamp bounds: act_min=10, act_max=-10
    do_reset();
    cfg(3'd7, 32'h0000_F60A);
    send(pk(100, -100, 0, -40), 32'hF60AF60A, 1'b0);
    drain();

    // Back-to-back stream with a downstream stall
    do_reset();
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(pk(2 * i, -2 * i, 20 * i, -40), {8'(i), 8'(-i), 8'(10 * i), 8'hEC}, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", {16'd0, out_count}, 32'd8);

    // Config write while busy is dropped and flagged
    do_reset();
    send(pk(100, -100, 0, 1000), 32'h32CE007F, 1'b0);
    cfg(3'd4, 32'd0);
    check("cfg_err_set", {31'd0, cfg_err}, 32'd1);
    drain();
    send(pk(100, -100, 0, 1000), 32'h32CE007F, 1'b0);
    drain();
    check("cfg_err_sticky", {31'd0, cfg_err}, 32'd1);

    // Reset flushes in-flight beats
    do_reset();
    check("cfg_err_cleared", {31'd0, cfg_err}, 32'd0);
    send(pk(1, 2, 3, 4), 32'h0, 1'b0);
    send(pk(5, 6, 7, 8), 32'h0, 1'b0);
    send(pk(9, 10, 11, 12), 32'h0, 1'b0);
    check("busy_before_reset", {31'd0, idle}, 32'd0);
    do_reset();
    repeat (10) @(negedge clk);
    #3;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_idle", {31'd0, idle}, 32'd1);
    check("flush_out_count", {16'd0, out_count}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
